// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generalised inter-stage pipeline register.
// Holds LANES payload words plus a valid bit. It also provides a flush
// that inserts a bubble, and a saturating counter of how many cycles the
// current valid contents have been held by a stall.
// The legal range for LANES is 1..16.
module pipe_stage_reg #(
  parameter int                         WIDTH      = 32,
  parameter int                         LANES      = 4,
  parameter logic [LANES*WIDTH-1:0]     BUBBLE_VAL = '0,
  parameter int                         CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          valid_in,
  input  logic [LANES*WIDTH-1:0]        din,
  output logic [LANES*WIDTH-1:0]        dout,
  output logic                          valid_out,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic                          stall_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             valid_reg;
  logic             valid_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_reg;

  // Next-state valid bit and stall counter.
  // The counter advances only while a real instruction is being held.
  // Every other case, including reset, flush, load and a held bubble,
  // returns it to zero.
  always_comb begin
    valid_next = valid_reg;
    cnt_next   = '0;
    if (reset || flush) begin
      valid_next = 1'b0;
    end else if (en) begin
      valid_next = valid_in;
    end else if (valid_reg) begin
      cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
    end
  end

  // Control state register.
  // The saturation flag comes from cnt_next, so it lines up with stall_cnt
  // in the same cycle.
  always_ff @(posedge clk) begin
    valid_reg <= valid_next;
    cnt_reg   <= cnt_next;
    sat_reg   <= (cnt_next == CNT_MAX);
  end

  // Payload lanes.
  // All lanes share the same load, hold and flush decision, and each lane
  // resets to its own slice of BUBBLE_VAL.
  // din is never sampled on a flush or a stall, so an X on din cannot
  // reach dout in those cases.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WIDTH-1:0] lane_reg;

      // Lane register with the priority reset > flush > en.
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          lane_reg <= BUBBLE_VAL[gi*WIDTH +: WIDTH];
        end else if (en) begin
          lane_reg <= din[gi*WIDTH +: WIDTH];
        end
      end

      assign dout[gi*WIDTH +: WIDTH] = lane_reg;
    end
  endgenerate

  assign valid_out = valid_reg;
  assign stall_cnt = cnt_reg;
  assign stall_sat = sat_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg.
// Two instances share the same stimulus:
//   dut_a uses CNT_W=3 and an all-zero bubble.
//   dut_b uses CNT_W=8 and a bubble whose lane0 is 32'hFFFFFFFF.
// Each step pushes the expected outputs of a behavioural model onto a
// queue. The queue is popped and compared after the clock edge.
module tb_pipe_stage_reg;

  localparam logic [127:0] BUB_A = '0;
  localparam logic [127:0] BUB_B = {96'h0, 32'hFFFFFFFF};

  logic         clk;
  logic         reset;
  logic         en;
  logic         flush;
  logic         valid_in;
  logic [127:0] din;
  logic [127:0] dout_a;
  logic [127:0] dout_b;
  logic         valid_a;
  logic         valid_b;
  logic [2:0]   cnt_a;
  logic [7:0]   cnt_b;
  logic         sat_a;
  logic         sat_b;

  typedef struct {
    logic [127:0] dout;
    logic         v;
    logic [7:0]   cnt;
    logic         sat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [127:0] md_a;
  logic [127:0] md_b;
  logic         mv_a;
  logic         mv_b;
  int           mc_a;
  int           mc_b;

  int vectors;
  int miscompares;

  logic [127:0] d1;
  logic [127:0] d2;
  logic [127:0] d3;
  logic [127:0] rnd;

  pipe_stage_reg #(.WIDTH(32), .LANES(4), .BUBBLE_VAL(BUB_A), .CNT_W(3)) dut_a (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
    .din(din), .dout(dout_a), .valid_out(valid_a), .stall_cnt(cnt_a), .stall_sat(sat_a)
  );

  pipe_stage_reg #(.WIDTH(32), .LANES(4), .BUBBLE_VAL(BUB_B), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
    .din(din), .dout(dout_b), .valid_out(valid_b), .stall_cnt(cnt_b), .stall_sat(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one edge, written directly from the priority
  // order reset > flush > en > hold.
  task automatic model_next(input logic [127:0] bub, input int maxc,
                            input logic r, input logic e, input logic f,
                            input logic vi, input logic [127:0] d,
                            input logic [127:0] cd, input logic cv, input int cc,
                            output logic [127:0] nd, output logic nv, output int nc);
    if (r || f) begin
      nd = bub; nv = 1'b0; nc = 0;
    end else if (e) begin
      nd = d; nv = vi; nc = 0;
    end else begin
      nd = cd; nv = cv;
      nc = cv ? ((cc < maxc) ? cc + 1 : cc) : 0;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic f,
                      input logic vi, input logic [127:0] d);
    exp_t ea;
    exp_t eb;
    logic [127:0] nd;
    logic nv;
    int nc;
    reset = r; en = e; flush = f; valid_in = vi; din = d;
    model_next(BUB_A, 7, r, e, f, vi, d, md_a, mv_a, mc_a, nd, nv, nc);
    md_a = nd; mv_a = nv; mc_a = nc;
    ea.dout = nd; ea.v = nv; ea.cnt = 8'(nc); ea.sat = (nc == 7);
    q_a.push_back(ea);
    model_next(BUB_B, 255, r, e, f, vi, d, md_b, mv_b, mc_b, nd, nv, nc);
    md_b = nd; mv_b = nv; mc_b = nc;
    eb.dout = nd; eb.v = nv; eb.cnt = 8'(nc); eb.sat = (nc == 255);
    q_b.push_back(eb);
    @(posedge clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    chk("a.dout",  dout_a,        ea.dout);
    chk("a.valid", valid_a,       ea.v);
    chk("a.cnt",   {5'b0, cnt_a}, ea.cnt);
    chk("a.sat",   sat_a,         ea.sat);
    chk("b.dout",  dout_b,        eb.dout);
    chk("b.valid", valid_b,       eb.v);
    chk("b.cnt",   cnt_b,         eb.cnt);
    chk("b.sat",   sat_b,         eb.sat);
    $display("t=%0t rst=%0b en=%0b fl=%0b vi=%0b | a: v=%0b cnt=%0d sat=%0b lane0=%h | b: v=%0b cnt=%0d lane0=%h",
             $time, r, e, f, vi, valid_a, cnt_a, sat_a, dout_a[31:0], valid_b, cnt_b, dout_b[31:0]);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    md_a = '0; md_b = '0; mv_a = 1'b0; mv_b = 1'b0; mc_a = 0; mc_b = 0;
    reset = 1'b1; en = 1'b0; flush = 1'b0; valid_in = 1'b0; din = '0;
    d1 = {64'h0, 32'h00003000, 32'h8C220004};
    d2 = {32'h00000003, 32'h00000002, 32'h00000001, 32'hA5A5A5A5};
    d3 = {32'hDEADBEEF, 32'h0BADF00D, 32'h00000040, 32'h24010001};

    // 1: reset for two cycles, then load
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    chk("t1.rst_dout_a", dout_a, 128'h0);
    chk("t1.rst_valid",  valid_a, 1'b0);
    chk("t1.rst_cnt",    cnt_b, 8'd0);
    chk("t1.rst_bub_b",  dout_b, BUB_B);
    step(0, 1, 0, 1, d1);
    chk("t1.lane0", dout_a[31:0], 32'h8C220004);
    chk("t1.lane1", dout_a[63:32], 32'h00003000);
    chk("t1.valid", valid_a, 1'b1);

    // 2: stall for five cycles while din changes, then reload
    for (int i = 1; i <= 5; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      step(0, 0, 0, 1'($urandom), rnd);
      chk("t2.cnt",  cnt_b, 128'(i));
      chk("t2.hold", dout_b, d1);
    end
    step(0, 1, 0, 1, d2);
    chk("t2.reload_cnt",  cnt_b, 8'd0);
    chk("t2.reload_dout", dout_a, d2);

    // 3: saturation on the 3-bit counter
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 0, 0, {$urandom, $urandom, $urandom, $urandom});
      chk("t3.cnt_a", {5'b0, cnt_a}, (i < 7) ? 128'(i) : 128'd7);
      chk("t3.sat_a", sat_a, (i >= 7) ? 1'b1 : 1'b0);
      chk("t3.cnt_b", cnt_b, 128'(i));
    end

    // 4: flush over stall, then a held bubble does not count
    step(0, 0, 1, 1, {$urandom, $urandom, $urandom, $urandom});
    chk("t4.dout",  dout_a, 128'h0);
    chk("t4.valid", valid_a, 1'b0);
    chk("t4.cnt",   cnt_b, 8'd0);
    step(0, 0, 0, 1, d3);
    chk("t4.bubble_cnt_a", {5'b0, cnt_a}, 8'd0);
    chk("t4.bubble_cnt_b", cnt_b, 8'd0);

    // 5: a flush colliding with a load wins
    step(0, 1, 0, 1, d2);
    step(0, 1, 1, 1, {96'h0, 32'h12345678});
    chk("t5.lane0_a", dout_a[31:0], 32'h0);
    chk("t5.dout_b",  dout_b, BUB_B);
    chk("t5.valid",   valid_b, 1'b0);

    // 6: reset during a stall with a nonzero bubble
    step(0, 1, 0, 1, d2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, '0);
    chk("t6.cnt4", cnt_b, 8'd4);
    step(1, 1, 0, 1, d3);
    chk("t6.lane0", dout_b[31:0], 32'hFFFFFFFF);
    chk("t6.valid", valid_b, 1'b0);
    chk("t6.cnt",   cnt_b, 8'd0);
    step(0, 1, 0, 1, d3);
    chk("t6.resume_dout",  dout_b, d3);
    chk("t6.resume_valid", valid_b, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
